// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is the fetch port, bit 1 the data port.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  grant_t r_last_grant;

  // On a tie the port that did not win last time is chosen
  always_comb begin
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last_grant == GRANT_INST) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GRANT_INST;
    end else if (advance && (grant != 2'b00)) begin
      r_last_grant <= grant[1] ? GRANT_DATA : GRANT_INST;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the core's fetch and data ports,
// one access in flight at a time, round-robin on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           inst_addr,
  input  logic                  inst_req,
  output logic                  inst_ack,
  output logic [31:0]           inst_q,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_data,
  input  logic [3:0]            data_mask,
  input  logic                  data_wren,
  input  logic                  data_req,
  output logic                  data_ack,
  output logic [31:0]           data_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [3:0]            mem_byteena,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [31:0]           mem_q
);

  state_t                r_state;
  grant_t                r_gnt;
  logic                  r_is_write;
  logic [1:0]            r_cnt;
  logic                  r_inst_ack;
  logic                  r_data_ack;
  logic                  r_mem_wren;
  logic                  r_mem_rden;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;
  logic [3:0]            r_mem_byteena;
  logic [31:0]           r_inst_q;
  logic [31:0]           r_data_q;

  logic [1:0]            w_grant;
  logic                  w_advance;
  logic                  w_fwd_inst;
  logic                  w_fwd_data;
  logic                  w_unused;

  assign w_advance = (r_state == IDLE);
  assign w_unused  = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0],
                       data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({data_req, inst_req}),
    .advance (w_advance),
    .grant   (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_gnt         <= GRANT_INST;
      r_is_write    <= 1'b0;
      r_cnt         <= 2'd0;
      r_inst_ack    <= 1'b0;
      r_data_ack    <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_rden    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= 32'd0;
      r_mem_byteena <= 4'd0;
      r_inst_q      <= 32'd0;
      r_data_q      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inst_ack <= 1'b0;
          r_data_ack <= 1'b0;
          if (w_grant[1]) begin
            r_gnt         <= GRANT_DATA;
            r_mem_addr    <= data_addr[ADDR_WIDTH+1:2];
            r_mem_data    <= data_data;
            r_mem_byteena <= data_mask;
            r_mem_wren    <= data_wren;
            r_mem_rden    <= ~data_wren;
            r_is_write    <= data_wren;
            r_state       <= ACCESS;
          end else if (w_grant[0]) begin
            r_gnt         <= GRANT_INST;
            r_mem_addr    <= inst_addr[ADDR_WIDTH+1:2];
            r_mem_byteena <= BYTE_EN_ALL;
            r_mem_wren    <= 1'b0;
            r_mem_rden    <= 1'b1;
            r_is_write    <= 1'b0;
            r_state       <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_mem_wren <= 1'b0;
          r_mem_rden <= 1'b0;
          if (r_is_write || (READ_LATENCY == 1)) begin
            r_inst_ack <= (r_gnt == GRANT_INST);
            r_data_ack <= (r_gnt == GRANT_DATA);
            r_state    <= ACK;
          end else begin
            r_cnt   <= 2'(READ_LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd1) begin
            r_inst_ack <= (r_gnt == GRANT_INST);
            r_data_ack <= (r_gnt == GRANT_DATA);
            r_state    <= ACK;
          end else begin
            r_cnt   <= r_cnt - 2'd1;
            r_state <= WAIT;
          end
        end
        ACK: begin
          r_inst_ack <= 1'b0;
          r_data_ack <= 1'b0;
          if (!r_is_write && (r_gnt == GRANT_INST)) begin
            r_inst_q <= mem_q;
          end else if (!r_is_write) begin
            r_data_q <= mem_q;
          end else begin
            r_data_q <= r_data_q;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM data only arrives in the ack cycle, so it is forwarded then; the q
  // registers hold it from the following cycle until the next read ack.
  assign w_fwd_inst = r_inst_ack & ~r_is_write;
  assign w_fwd_data = r_data_ack & ~r_is_write;

  assign inst_ack    = r_inst_ack;
  assign data_ack    = r_data_ack;
  assign inst_q      = w_fwd_inst ? mem_q : r_inst_q;
  assign data_q      = w_fwd_data ? mem_q : r_data_q;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_byteena = r_mem_byteena;
  assign mem_wren    = r_mem_wren;
  assign mem_rden    = r_mem_rden;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LATENCY=1, one at 3,
// each with its own synchronous RAM model.
module tb_mem_port_arbiter;

  localparam int AW = 14;

  typedef struct {
    bit          inst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic [13:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_q;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, reset3;
  logic [31:0] inst_addr, data_addr, data_data;
  logic [3:0]  data_mask;
  logic        data_wren;
  logic        inst_req1, data_req1, inst_req3, data_req3;

  logic        ia1, da1, wr1, rd1, ia3, da3, wr3, rd3;
  logic [31:0] iq1, dq1, md1, mq1, iq3, dq3, md3, mq3;
  logic [13:0] ma1, ma3;
  logic [3:0]  be1, be3;

  logic        ld_en;
  int          ld_sel;
  logic [13:0] ld_addr;
  logic [31:0] ld_val;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .inst_addr(inst_addr), .inst_req(inst_req1), .inst_ack(ia1), .inst_q(iq1),
    .data_addr(data_addr), .data_data(data_data), .data_mask(data_mask),
    .data_wren(data_wren), .data_req(data_req1), .data_ack(da1), .data_q(dq1),
    .mem_addr(ma1), .mem_data(md1), .mem_byteena(be1), .mem_wren(wr1),
    .mem_rden(rd1), .mem_q(mq1)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .inst_addr(inst_addr), .inst_req(inst_req3), .inst_ack(ia3), .inst_q(iq3),
    .data_addr(data_addr), .data_data(data_data), .data_mask(data_mask),
    .data_wren(data_wren), .data_req(data_req3), .data_ack(da3), .data_q(dq3),
    .mem_addr(ma3), .mem_data(md3), .mem_byteena(be3), .mem_wren(wr3),
    .mem_rden(rd3), .mem_q(mq3)
  );

  // RAM models: data is only driven in the exact cycle it is due, garbage otherwise
  logic [31:0] ram1 [0:(1<<AW)-1];
  logic [31:0] ram3 [0:(1<<AW)-1];
  logic        v1, v3a, v3b, v3c;
  logic [31:0] d1, d3a, d3b, d3c;

  always @(posedge clk) begin
    if (ld_en && ld_sel == 1) ram1[ld_addr] <= ld_val;
    if (ld_en && ld_sel == 3) ram3[ld_addr] <= ld_val;
    if (wr1) for (int b = 0; b < 4; b++) if (be1[b]) ram1[ma1][8*b +: 8] <= md1[8*b +: 8];
    if (wr3) for (int b = 0; b < 4; b++) if (be3[b]) ram3[ma3][8*b +: 8] <= md3[8*b +: 8];
    v1  <= reset1 ? 1'b0 : rd1;
    d1  <= ram1[ma1];
    v3a <= reset3 ? 1'b0 : rd3;
    v3b <= v3a;
    v3c <= v3b;
    d3a <= ram3[ma3];
    d3b <= d3a;
    d3c <= d3b;
  end

  assign mq1 = v1  ? d1  : 32'hBAD0BAD0;
  assign mq3 = v3c ? d3c : 32'hBAD0BAD0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic load(input int sel, input logic [13:0] a, input logic [31:0] v);
    ld_sel = sel; ld_addr = a; ld_val = v; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic sample(input int sel, output logic ia, output logic da, output logic wr,
                        output logic rd, output logic [13:0] ma, output logic [3:0] be,
                        output logic [31:0] md, output logic [31:0] iq, output logic [31:0] dq);
    if (sel == 1) begin
      ia = ia1; da = da1; wr = wr1; rd = rd1; ma = ma1; be = be1; md = md1; iq = iq1; dq = dq1;
    end else begin
      ia = ia3; da = da3; wr = wr3; rd = rd3; ma = ma3; be = be3; md = md3; iq = iq3; dq = dq3;
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    logic ia, da, wr, rd;
    logic [13:0] ma;
    logic [3:0] be;
    logic [31:0] md, iq, dq;
    sample(sel, ia, da, wr, rd, ma, be, md, iq, dq);
    chk({tag, "_ctrl"}, {28'd0, ia, da, wr, rd}, 32'd0);
    chk({tag, "_addr"}, {18'd0, ma}, 32'd0);
    chk({tag, "_wdata"}, md, 32'd0);
    chk({tag, "_be"}, {28'd0, be}, 32'd0);
    chk({tag, "_iq"}, iq, 32'd0);
    chk({tag, "_dq"}, dq, 32'd0);
  endtask

  task automatic set_req(input int sel, input bit inst, input logic v);
    if (sel == 1 && inst)  inst_req1 = v;
    if (sel == 1 && !inst) data_req1 = v;
    if (sel == 3 && inst)  inst_req3 = v;
    if (sel == 3 && !inst) data_req3 = v;
  endtask

  // One transaction on one DUT; k counts cycles from the first IDLE sample
  task automatic run_txn(input int sel, input vec_t v, input int exp_lat, input string tag);
    logic ia, da, wr, rd;
    logic [13:0] ma, s_ma;
    logic [3:0] be, s_be;
    logic [31:0] md, iq, dq, s_md, q;
    int lat, strobes, strobe_k;
    bit stray, s_wr;
    lat = -1; strobes = 0; strobe_k = -1; stray = 1'b0; s_wr = 1'b0;
    s_ma = '0; s_be = '0; s_md = '0; q = '0;
    @(posedge clk); #1;
    if (v.inst) inst_addr = v.addr;
    else begin
      data_addr = v.addr; data_data = v.wd; data_mask = v.mask; data_wren = v.wr;
    end
    set_req(sel, v.inst, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sample(sel, ia, da, wr, rd, ma, be, md, iq, dq);
      if (wr || rd) begin
        strobes++; strobe_k = k; s_wr = wr; s_ma = ma; s_be = be; s_md = md;
      end
      if (v.inst ? da : ia) stray = 1'b1;
      if (v.inst ? ia : da) begin
        lat = k; q = v.inst ? iq : dq;
        break;
      end
    end
    @(posedge clk); #1;
    set_req(sel, v.inst, 1'b0);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_strobes"}, strobes, 1);
    chk({tag, "_strobe_cyc"}, strobe_k, 1);
    chk({tag, "_maddr"}, {18'd0, s_ma}, {18'd0, v.exp_maddr});
    chk({tag, "_be"}, {28'd0, s_be}, {28'd0, v.exp_be});
    chk({tag, "_kind"}, {31'd0, s_wr}, {31'd0, v.wr});
    chk({tag, "_stray"}, {31'd0, stray}, 32'd0);
    if (v.wr) chk({tag, "_wdata"}, s_md, v.wd);
    else      chk({tag, "_q"}, q, v.exp_q);
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    logic ia, da, wr, rd;
    logic [13:0] ma;
    logic [3:0] be;
    logic [31:0] md, iq, dq;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    14'd4, 4'hF,    32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h12345678,  4'b0011, 14'd8, 4'b0011, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'hF,    14'd8, 4'hF,    32'hFFFF5678};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0024, 32'h13572468,  4'h0,    14'd9, 4'h0,    32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'b0101, 14'd9, 4'b0101, 32'hA5A5A5A5};
    tbl[5] = '{1'b1, 1'b0, 32'h0001_000E, 32'h0,         4'h0,    14'd3, 4'hF,    32'h01020304};
    tbl[6] = '{1'b0, 1'b1, 32'h8000_000D, 32'hAABBCCDD,  4'b1100, 14'd3, 4'b1100, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0,    14'd3, 4'hF,    32'hAABB0304};

    reset1 = 1'b1; reset3 = 1'b1;
    inst_req1 = 1'b0; data_req1 = 1'b0; inst_req3 = 1'b0; data_req3 = 1'b0;
    inst_addr = '0; data_addr = '0; data_data = '0; data_mask = '0; data_wren = 1'b0;
    ld_en = 1'b0; ld_sel = 0; ld_addr = '0; ld_val = '0;
    repeat (3) @(posedge clk);
    #1;
    load(1, 14'd4, 32'hDEADBEEF);
    load(1, 14'd8, 32'hFFFFFFFF);
    load(1, 14'd9, 32'hA5A5A5A5);
    load(1, 14'd3, 32'h01020304);
    load(3, 14'd4, 32'hCAFEF00D);
    load(3, 14'd5, 32'h0BADF00D);
    load(3, 14'd6, 32'h11223344);
    @(negedge clk);
    check_zero(1, "rst1");
    check_zero(3, "rst3");
    @(posedge clk); #1;
    reset1 = 1'b0; reset3 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(1, tbl[i], 2, $sformatf("vec%0d", i));
    end

    // Contention straight after reset: DATA, INST, DATA, INST at 3-cycle spacing
    @(posedge clk); #1; reset1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset1 = 1'b0;
    inst_addr = 32'h10; data_addr = 32'h20; data_wren = 1'b0; data_mask = 4'hF;
    inst_req1 = 1'b1; data_req1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] exp_acks;
      @(negedge clk);
      exp_acks = (k == 2 || k == 8) ? 2'b01 : ((k == 5 || k == 11) ? 2'b10 : 2'b00);
      chk($sformatf("cont_ack_k%0d", k), {30'd0, ia1, da1}, {30'd0, exp_acks});
      if (k == 2) chk("cont_dq", dq1, 32'hFFFF5678);
      if (k == 5) chk("cont_iq", iq1, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    inst_req1 = 1'b0; data_req1 = 1'b0;
    for (int k = 12; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("cont_idle_k%0d", k), {30'd0, ia1, da1}, 32'd0);
    end

    // READ_LATENCY=3 instance
    v = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 14'd4, 4'hF, 32'hCAFEF00D};
    run_txn(3, v, 4, "rl3_fetch");
    repeat (3) @(negedge clk);
    chk("rl3_iq_hold", iq3, 32'hCAFEF00D);
    v = '{1'b0, 1'b1, 32'h18, 32'h55667788, 4'hF, 14'd6, 4'hF, 32'h0};
    run_txn(3, v, 2, "rl3_wr");
    v = '{1'b0, 1'b0, 32'h18, 32'h0, 4'hF, 14'd6, 4'hF, 32'h55667788};
    run_txn(3, v, 4, "rl3_rd");

    // Reset lands in the WAIT cycle of a fetch: no ack, everything cleared
    @(posedge clk); #1;
    inst_addr = 32'h14; inst_req3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_rden", {31'd0, rd3}, 32'd1);
    @(posedge clk); #1;
    reset3 = 1'b1; inst_req3 = 1'b0;
    @(negedge clk);
    chk("rst_wait_noack_k2", {31'd0, ia3}, 32'd0);
    @(negedge clk);
    check_zero(3, "rst_wait");
    @(posedge clk); #1;
    reset3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample(3, ia, da, wr, rd, ma, be, md, iq, dq);
      chk($sformatf("rst_wait_quiet%0d", k), {28'd0, ia, da, wr, rd}, 32'd0);
    end
    v = '{1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 14'd5, 4'hF, 32'h0BADF00D};
    run_txn(3, v, 4, "rl3_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
